// File: rtl/sdfa_sat_accumulator.sv
// Multi-lane saturating accumulator for SDFA neuron-potential updates.
// Optional macro SDFA_ACC_SAT_CNT_EN adds a 16-bit saturating clamp-event counter (SAT_CNT).
module sdfa_sat_accumulator #(
  parameter int CAL_BIT     = 10,
  parameter int LANES       = 4,
  parameter int ACC_LEN_BIT = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     START,
  input  logic [ACC_LEN_BIT-1:0]   ACC_LEN,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [LANES*CAL_BIT-1:0] IN_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [LANES*CAL_BIT-1:0] OUT_DATA,
  output logic [LANES-1:0]         SAT_FLAG,
`ifdef SDFA_ACC_SAT_CNT_EN
  output logic [15:0]              SAT_CNT,
`endif
  output logic                     BUSY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  localparam logic [CAL_BIT-1:0] SAT_MAX = {1'b0, {(CAL_BIT-1){1'b1}}};
  localparam logic [CAL_BIT-1:0] SAT_MIN = {1'b1, {(CAL_BIT-1){1'b0}}};

  logic [1:0]             state_q, state_d;
  logic [CAL_BIT-1:0]     acc_q [LANES];
  logic [CAL_BIT-1:0]     acc_d [LANES];
  logic [CAL_BIT-1:0]     sat_sum [LANES];
  logic [LANES-1:0]       clamp;
  logic [LANES-1:0]       sat_q, sat_d;
  logic [ACC_LEN_BIT-1:0] len_q, len_d;
  logic [ACC_LEN_BIT-1:0] cnt_q, cnt_d;
  logic                   beat_fire;

  assign IN_READY  = (state_q == ACCUM) & EN;
  assign OUT_VALID = (state_q == OUTPUT);
  assign BUSY      = (state_q != IDLE);
  assign SAT_FLAG  = sat_q;
  assign beat_fire = IN_VALID & IN_READY;

  // Overflow is detected from operand and result sign bits of the wrapped sum.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      logic [CAL_BIT-1:0] a, b, s;
      a = acc_q[i];
      b = IN_DATA[i*CAL_BIT +: CAL_BIT];
      s = a + b;
      clamp[i]   = 1'b0;
      sat_sum[i] = s;
      if (!a[CAL_BIT-1] && !b[CAL_BIT-1] && s[CAL_BIT-1]) begin
        sat_sum[i] = SAT_MAX;
        clamp[i]   = 1'b1;
      end else if (a[CAL_BIT-1] && b[CAL_BIT-1] && !s[CAL_BIT-1]) begin
        sat_sum[i] = SAT_MIN;
        clamp[i]   = 1'b1;
      end
    end
  end

  always_comb begin
    OUT_DATA = '0;
    for (int i = 0; i < LANES; i++) begin
      OUT_DATA[i*CAL_BIT +: CAL_BIT] = acc_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    for (int i = 0; i < LANES; i++) begin
      acc_d[i] = acc_q[i];
    end
    unique case (state_q)
      IDLE: begin
        if (EN && START) begin
          len_d = ACC_LEN;
          cnt_d = '0;
          sat_d = '0;
          for (int i = 0; i < LANES; i++) begin
            acc_d[i] = '0;
          end
          state_d = (ACC_LEN == '0) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (beat_fire) begin
          for (int i = 0; i < LANES; i++) begin
            acc_d[i] = sat_sum[i];
          end
          sat_d = sat_q | clamp;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (EN && OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

`ifdef SDFA_ACC_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [16:0] sat_cnt_sum;

  // One increment per clamping lane per accepted beat, saturating at all-ones.
  always_comb begin
    sat_cnt_sum = {1'b0, sat_cnt_q};
    for (int i = 0; i < LANES; i++) begin
      sat_cnt_sum = sat_cnt_sum + {16'd0, clamp[i] & beat_fire};
    end
    sat_cnt_d = sat_cnt_sum[16] ? 16'hFFFF : sat_cnt_sum[15:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign SAT_CNT = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sdfa_sat_accumulator.sv
// Bench for sdfa_sat_accumulator: directed and randomized runs against an integer-arithmetic model.
module tb_sdfa_sat_accumulator;
  localparam int CB   = 10;
  localparam int LN   = 4;
  localparam int LB   = 8;
  localparam int W    = LN * CB;
  localparam int MAXV = (1 << (CB - 1)) - 1;
  localparam int MINV = -(1 << (CB - 1));

  logic          CLK, RST, EN, START, IN_VALID, IN_READY, OUT_VALID, OUT_READY, BUSY;
  logic [LB-1:0] ACC_LEN;
  logic [W-1:0]  IN_DATA, OUT_DATA;
  logic [LN-1:0] SAT_FLAG;
`ifdef SDFA_ACC_SAT_CNT_EN
  logic [15:0]   SAT_CNT;
`endif

  sdfa_sat_accumulator #(.CAL_BIT(CB), .LANES(LN), .ACC_LEN_BIT(LB)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .ACC_LEN(ACC_LEN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .SAT_FLAG(SAT_FLAG),
`ifdef SDFA_ACC_SAT_CNT_EN
    .SAT_CNT(SAT_CNT),
`endif
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int            checks = 0;
  int            errors = 0;
  int            exp_acc [LN];
  logic [LN-1:0] exp_sat;
  int            exp_cnt = 0;
  logic [W-1:0]  beats [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] pack(input int a, input int b, input int c, input int d);
    logic [W-1:0] v;
    v = '0;
    v[0*CB +: CB] = a[CB-1:0];
    v[1*CB +: CB] = b[CB-1:0];
    v[2*CB +: CB] = c[CB-1:0];
    v[3*CB +: CB] = d[CB-1:0];
    return v;
  endfunction

  function automatic logic [W-1:0] exp_vec();
    logic [W-1:0] v;
    v = '0;
    for (int l = 0; l < LN; l++) v[l*CB +: CB] = exp_acc[l][CB-1:0];
    return v;
  endfunction

  // Reference: exact integer sum, clamped into the signed range after every beat.
  task automatic model_beat(input logic [W-1:0] b);
    for (int l = 0; l < LN; l++) begin
      logic signed [CB-1:0] x;
      int s;
      x = b[l*CB +: CB];
      s = exp_acc[l] + int'(x);
      if (s > MAXV || s < MINV) begin
        s = (s > MAXV) ? MAXV : MINV;
        exp_sat[l] = 1'b1;
        if (exp_cnt < 65535) exp_cnt++;
      end
      exp_acc[l] = s;
    end
  endtask

  task automatic do_run(input int len, input bit gaps, input int hold);
    int acc, cyc;
    bit v;
    for (int l = 0; l < LN; l++) exp_acc[l] = 0;
    exp_sat = '0;
    START = 1'b1; ACC_LEN = LB'(len); EN = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    tick();
    START = 1'b0;
    chk("busy_after_start", BUSY, 1);
    acc = 0; cyc = 0;
    while (acc < len && cyc < 1000) begin
      EN       = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      v        = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      IN_VALID = v;
      IN_DATA  = v ? beats[acc] : W'({$urandom, $urandom});
      START    = $urandom_range(0, 1);
      ACC_LEN  = LB'($urandom);
      #1;
      chk("in_ready", IN_READY, EN);
      chk("out_valid_low_in_accum", OUT_VALID, 0);
      tick();
      if (EN && v) begin
        model_beat(beats[acc]);
        acc++;
      end
      cyc++;
    end
    chk("beats_accepted", acc, len);
    START = 1'b0; EN = 1'b1; IN_VALID = 1'b0; IN_DATA = W'({$urandom, $urandom});
    #1;
    chk("out_valid_latency", OUT_VALID, 1);
    chk("in_ready_in_output", IN_READY, 0);
    chk("out_data", OUT_DATA, exp_vec());
    chk("sat_flag", SAT_FLAG, exp_sat);
`ifdef SDFA_ACC_SAT_CNT_EN
    chk("sat_cnt", SAT_CNT, exp_cnt);
`endif
    EN = 1'b0; OUT_READY = 1'b1;
    tick();
    chk("en_low_no_handshake", OUT_VALID, 1);
    EN = 1'b1; OUT_READY = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_out_data", OUT_DATA, exp_vec());
      chk("hold_busy", BUSY, 1);
      chk("hold_sat_flag", SAT_FLAG, exp_sat);
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("after_handshake_valid", OUT_VALID, 0);
    chk("after_handshake_busy", BUSY, 0);
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; START = 1'b0; ACC_LEN = '0;
    IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
    #3;
    chk("rst_busy", BUSY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_sat_flag", SAT_FLAG, 0);
    tick();
    RST = 1'b0;
    tick();

    // Lane0 plain sum, lane1 clamps to MAX then recovers.
    beats = {pack(100, 400, 0, 0), pack(200, 300, 0, 0), pack(50, -100, 0, 0)};
    do_run(3, 1'b0, 0);
    chk("tp1_lane0", OUT_DATA[0 +: CB], 350);
    chk("tp1_lane1", OUT_DATA[CB +: CB], 411);
    chk("tp1_flags", SAT_FLAG, 4'b0010);

    beats = {pack(0, 0, -300, 0), pack(0, 0, -300, 0)};
    do_run(2, 1'b0, 0);
    chk("tp2_lane2", OUT_DATA[2*CB +: CB], 10'h200);
    chk("tp2_lane3", OUT_DATA[3*CB +: CB], 0);
    chk("tp2_flags", SAT_FLAG, 4'b0100);

    do_run(0, 1'b0, 5);

    beats = {pack(10, -20, 30, 511), pack(1, 2, 3, 4), pack(-5, 5, -5, 5), pack(7, 8, 9, 10)};
    do_run(4, 1'b1, 2);

    // Abort a run mid-way; the next run must show no residue.
    beats = {pack(400, 400, -400, 1), pack(400, 400, -400, 1)};
    START = 1'b1; ACC_LEN = 8'd4; EN = 1'b1;
    tick();
    START = 1'b0; IN_VALID = 1'b1;
    for (int k = 0; k < 2; k++) begin
      IN_DATA = beats[k];
      tick();
    end
    RST = 1'b1;
    #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_out_valid", OUT_VALID, 0);
    chk("abort_in_ready", IN_READY, 0);
    chk("abort_out_data", OUT_DATA, 0);
    chk("abort_sat_flag", SAT_FLAG, 0);
    exp_cnt = 0;
    IN_VALID = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    beats = {pack(7, 0, 0, 0)};
    do_run(1, 1'b0, 0);
    chk("after_abort_lane0", OUT_DATA[0 +: CB], 7);
    chk("after_abort_flags", SAT_FLAG, 0);

    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 10);
      beats = {};
      for (int k = 0; k < len; k++) beats.push_back(W'({$urandom, $urandom}));
      do_run(len, 1'b1, $urandom_range(0, 3));
    end

    beats = {};
    for (int k = 0; k < 20; k++) beats.push_back(pack(500, -500, 300, -1));
    do_run(20, 1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
